freq_meter: RTL and testbench

- Hardware frequency meter. Counts rising edges of an asynchronous input signal over a fixed gate window timed by the 50 MHz system clock.
- It is the measuring end of the LED blinkers and the auxiliary clock-select path. It lets the board report the frequency of a blink output or a divided CLK_AUX on-chip, with no external instrument.
- Results are presented as a count, qualified by a one-cycle valid pulse.

---
 rtl/freq_meter_pkg.sv | 24 ++
 rtl/freq_meter_sync_edge_det.sv | 36 +++
 rtl/freq_meter.sv | 107 ++++++++++
 tb/tb_freq_meter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared types and sizing helpers for the frequency meter
//
// Contents:
//   state_t     measurement FSM states
//   CNT_W_DEF   default edge counter / result width
//   gate_cnt_w  width needed for a gate counter spanning 0..gate_cycles-1
`timescale 1ns/1ps
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int CNT_W_DEF = 32;

  // A one-cycle gate still needs a 1-bit counter.
  function automatic int gate_cnt_w(input int gate_cycles);
    return (gate_cycles > 1) ? $clog2(gate_cycles) : 1;
  endfunction

endpackage

// File: rtl/freq_meter_sync_edge_det.sv
// rtl/freq_meter_sync_edge_det.sv - input synchronizer with rising-edge detect
//
// Ports:
//   CLK       system clock
//   RST       asynchronous active-high reset
//   sig_in    asynchronous input
//   sig_s     sig_in after SYNC_STAGES flip-flops
//   sig_rise  one-cycle pulse on a synchronized rising edge (sig_s & ~sig_d)
`timescale 1ns/1ps
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic sig_in,
  output logic sig_s,
  output logic sig_rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
      sig_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sig_d  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sig_s    = sync_q[SYNC_STAGES-1];
  assign sig_rise = sig_s & ~sig_d;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated rising-edge counter reporting input frequency
//
// Ports:
//   CLK     system clock (50 MHz)
//   RST     asynchronous active-high reset
//   sig_in  signal to measure, asynchronous to CLK
//   start   one-cycle request to begin a measurement (taken in IDLE only)
//   cont    re-arm automatically after each result (sampled in DONE)
//   busy    high in ARM, GATE and DONE
//   freq    last completed edge count, held until the next result
//   valid   one-cycle pulse when freq/ovf are updated
//   ovf     last result saturated
`timescale 1ns/1ps
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic [CNT_W-1:0] freq,
  output logic             valid,
  output logic             ovf
);

  localparam int GW = gate_cnt_w(GATE_CYCLES);

  state_t           state, state_nx;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             sat;
  logic             rise;
  logic             gate_last;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK      (CLK),
    .RST      (RST),
    .sig_in   (sig_in),
    .sig_s    (),
    .sig_rise (rise)
  );

  assign gate_last = (gate_cnt == GW'(GATE_CYCLES - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = ARM;
      end
      ARM:     state_nx = GATE;
      GATE:    if (gate_last) state_nx = DONE;
      DONE:    state_nx = cont ? ARM : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Edges are counted in every GATE cycle; an edge arriving once the
  // counter is full only records the saturation, it never wraps.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
    end else if (state == ARM) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
    end else if (state == GATE) begin
      gate_cnt <= gate_cnt + 1'b1;
      if (rise) begin
        if (&edge_cnt) sat      <= 1'b1;
        else           edge_cnt <= edge_cnt + 1'b1;
      end
    end
  end

  // Result registers load on the DONE cycle; valid is registered alongside
  // so it is high exactly while the new freq/ovf are first visible.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      freq  <= '0;
      ovf   <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= (state == DONE);
      if (state == DONE) begin
        freq <= edge_cnt;
        ovf  <= sat;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - directed self-checking bench for freq_meter
`timescale 1ns/1ps
module tb_freq_meter;

  localparam int G1 = 1000;
  localparam int W1 = 16;
  localparam int G2 = 2000;
  localparam int W2 = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic          cont = 1'b0;
  logic          sig_in;
  logic          sig_man = 1'b0;
  logic          sig_gen = 1'b0;
  logic          use_gen = 1'b0;
  int            half_ns = 0;

  logic          busy1, valid1, ovf1;
  logic [W1-1:0] freq1;
  logic          busy2, valid2, ovf2;
  logic [W2-1:0] freq2;

  int checks = 0;
  int passes = 0;
  int n;
  int cnt;

  assign sig_in = use_gen ? sig_gen : sig_man;

  always #10 CLK = ~CLK;

  // Generator toggles land 3 ns after a negedge plus multiples of 10 ns,
  // so they never coincide with a rising clock edge.
  always begin
    wait (half_ns > 0);
    #(half_ns) sig_gen = ~sig_gen;
  end

  freq_meter #(.GATE_CYCLES(G1), .CNT_W(W1), .SYNC_STAGES(2)) dut1 (
    .CLK(CLK), .RST(RST), .sig_in(sig_in), .start(start), .cont(cont),
    .busy(busy1), .freq(freq1), .valid(valid1), .ovf(ovf1)
  );

  freq_meter #(.GATE_CYCLES(G2), .CNT_W(W2), .SYNC_STAGES(2)) dut2 (
    .CLK(CLK), .RST(RST), .sig_in(sig_in), .start(start), .cont(cont),
    .busy(busy2), .freq(freq2), .valid(valid2), .ovf(ovf2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic start_gen(input int h);
    @(negedge CLK);
    #3;
    sig_gen = 1'b0;
    half_ns = h;
    use_gen = 1'b1;
  endtask

  task automatic stop_gen();
    half_ns = 0;
    use_gen = 1'b0;
    sig_man = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic wait_valid(input int which, input int max_cyc, output int nc);
    nc = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(posedge CLK);
      #1;
      if ((which == 1 && valid1 === 1'b1) || (which == 2 && valid2 === 1'b1)) begin
        nc = i;
        break;
      end
    end
  endtask

  task automatic count_valid(input int cycles, output int c);
    c = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge CLK);
      #1;
      if (valid1 === 1'b1) c++;
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a toggling input
    start_gen(50);
    repeat (20) @(negedge CLK);
    check("rst_busy", busy1, 0);
    check("rst_freq", freq1, 0);
    check("rst_valid", valid1, 0);
    check("rst_ovf", ovf1, 0);
    check("rst_freq2", freq2, 0);
    RST = 1'b0;
    stop_gen();
    count_valid(2000, cnt);
    check("idle_no_valid", cnt, 0);

    // 10 MHz single measurement
    start_gen(50);
    start_pulse();
    wait_valid(1, 1200, n);
    check("mhz10_latency", n, 1002);
    check("mhz10_freq_range", (freq1 >= 199 && freq1 <= 201), 1);
    check("mhz10_ovf", ovf1, 0);
    check("mhz10_busy_after", busy1, 0);
    @(posedge CLK); #1;
    check("mhz10_valid_width", valid1, 0);

    // Blink rate in continuous mode
    do_reset();
    start_gen(600);
    cont = 1'b1;
    start_pulse();
    for (int k = 0; k < 3; k++) begin
      wait_valid(1, 1100, n);
      check($sformatf("blink_spacing_%0d", k), n, 1002);
      check($sformatf("blink_freq_%0d", k), (freq1 == 16 || freq1 == 17), 1);
    end
    cont = 1'b0;
    do_reset();
    stop_gen();

    // Window boundary: edge in last GATE cycle counts, one cycle later it does not
    repeat (5) @(negedge CLK);
    start_pulse();
    repeat (G1 - 2) @(posedge CLK);
    @(negedge CLK);
    sig_man = 1'b1;
    wait_valid(1, 100, n);
    check("boundary_last_gate", freq1, 1);
    @(negedge CLK);
    sig_man = 1'b0;
    repeat (5) @(negedge CLK);
    start_pulse();
    repeat (G1 - 1) @(posedge CLK);
    @(negedge CLK);
    sig_man = 1'b1;
    wait_valid(1, 100, n);
    check("boundary_in_done", freq1, 0);
    @(negedge CLK);
    sig_man = 1'b0;

    // Saturation on the narrow instance
    do_reset();
    start_gen(40);
    start_pulse();
    wait_valid(2, 2200, n);
    check("sat_latency", n, 2002);
    check("sat_freq", freq2, 255);
    check("sat_ovf", ovf2, 1);
    check("sat_wide_freq_range", (freq1 >= 249 && freq1 <= 251), 1);
    check("sat_wide_ovf", ovf1, 0);
    stop_gen();
    start_pulse();
    wait_valid(2, 2200, n);
    check("idle_run_freq", freq2, 0);
    check("idle_run_ovf", ovf2, 0);
    check("idle_run_wide_freq", freq1, 0);

    // Start during GATE is ignored
    do_reset();
    start_gen(50);
    start_pulse();
    repeat (500) @(posedge CLK);
    start_pulse();
    count_valid(1200, cnt);
    check("ignore_start_one_valid", cnt, 1);
    check("ignore_start_freq_range", (freq1 >= 199 && freq1 <= 201), 1);

    // Reset in mid-GATE aborts with no result
    start_pulse();
    repeat (500) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("abort_busy", busy1, 0);
    check("abort_freq", freq1, 0);
    check("abort_valid", valid1, 0);
    check("abort_ovf", ovf1, 0);
    RST = 1'b0;
    count_valid(1500, cnt);
    check("abort_no_valid", cnt, 0);
    start_pulse();
    wait_valid(1, 1200, n);
    check("rerun_latency", n, 1002);
    check("rerun_freq_range", (freq1 >= 199 && freq1 <= 201), 1);
    stop_gen();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
